// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-port TCDM bank among NB_REQ hci_mem-style requesters.
// Optional zero-fill sweep of the bank after reset is enabled by defining TCDM_BANK_INIT_EN.
module tcdm_bank_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int BANK_SIZE  = 256,
  parameter int ADDR_WIDTH = 32,
  localparam int BANK_AW   = $clog2(BANK_SIZE)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_REQ-1:0]                    req_i,
  output logic [NB_REQ-1:0]                    gnt_o,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
  input  logic [NB_REQ-1:0]                    wen_i,
  input  logic [NB_REQ-1:0][3:0]               be_i,
  input  logic [NB_REQ-1:0][31:0]              data_i,
  output logic [NB_REQ-1:0][31:0]              r_data_o,
  output logic [NB_REQ-1:0]                    r_valid_o,
  output logic                                 bank_req_o,
  output logic                                 bank_wen_o,
  output logic [3:0]                           bank_be_o,
  output logic [BANK_AW-1:0]                   bank_add_o,
  output logic [31:0]                          bank_wdata_o,
  input  logic [31:0]                          bank_rdata_i,
  output logic                                 init_done_o
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [NB_REQ-1:0] r_valid_p1;
  logic [PTR_W-1:0]  w_win;
  logic              w_any;
  logic              w_en;
  logic              w_grant;
  logic [NB_REQ-1:0] w_gnt;
  logic              w_unused;

  // Only the word-address field of add_i reaches the bank; the rest is intentionally dropped.
  assign w_unused = ^add_i;

`ifdef TCDM_BANK_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state;
  logic [BANK_AW-1:0] r_cnt;
  logic               r_init_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == BANK_AW'(BANK_SIZE - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_RUN;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  assign init_done_o = r_init_done;
  assign w_en        = r_init_done & ~rst_i;
`else
  assign init_done_o = 1'b1;
  assign w_en        = ~rst_i;
`endif

  // First requester at or after the pointer, wrapping modulo NB_REQ.
  always_comb begin
    int k;
    k     = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      k = (int'(r_ptr) + i) % NB_REQ;
      if (!w_any && req_i[k]) begin
        w_any = 1'b1;
        w_win = PTR_W'(k);
      end
    end
  end

  assign w_grant = w_any & w_en;
  assign w_gnt   = w_grant ? (NB_REQ'(1) << w_win) : '0;
  assign gnt_o   = w_gnt;

  always_comb begin
    bank_req_o   = w_grant;
    bank_wen_o   = wen_i[w_win];
    bank_be_o    = be_i[w_win];
    bank_add_o   = add_i[w_win][BANK_AW+1:2];
    bank_wdata_o = data_i[w_win];
`ifdef TCDM_BANK_INIT_EN
    if (r_state == S_INIT) begin
      bank_req_o   = ~rst_i;
      bank_wen_o   = 1'b0;
      bank_be_o    = 4'hF;
      bank_add_o   = r_cnt;
      bank_wdata_o = '0;
    end
`endif
  end

  // Response stage: the bank answers one cycle after the grant, writes included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_valid_p1 <= '0;
    end else begin
      r_valid_p1 <= w_gnt;
      if (w_grant) begin
        r_ptr <= (w_win == PTR_W'(NB_REQ - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign r_valid_o = r_valid_p1;
  assign r_data_o  = {NB_REQ{bank_rdata_i}};

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: directed vector table, hand sequences and randomized traffic
// against a queue-free reference model of the arbitration rules and the bank contents.
module tb_tcdm_bank_arbiter;
  localparam int NB = 4;
  localparam int BS = 256;
  localparam int AW = 32;
  localparam int BAW = 8;

  logic                   clk;
  logic                   rst;
  logic [NB-1:0]          req;
  logic [NB-1:0]          gnt;
  logic [NB-1:0][AW-1:0]  add;
  logic [NB-1:0]          wen;
  logic [NB-1:0][3:0]     be;
  logic [NB-1:0][31:0]    data;
  logic [NB-1:0][31:0]    r_data;
  logic [NB-1:0]          r_valid;
  logic                   bank_req;
  logic                   bank_wen;
  logic [3:0]             bank_be;
  logic [BAW-1:0]         bank_add;
  logic [31:0]            bank_wdata;
  logic [31:0]            bank_rdata;
  logic                   init_done;

  tcdm_bank_arbiter #(.NB_REQ(NB), .BANK_SIZE(BS), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(data), .r_data_o(r_data), .r_valid_o(r_valid),
    .bank_req_o(bank_req), .bank_wen_o(bank_wen), .bank_be_o(bank_be),
    .bank_add_o(bank_add), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata),
    .init_done_o(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pat(int i);
    if (i == 7) return 32'h0;
    return {8'hC0, 8'(i), 8'h5A, 8'(255 - i)};
  endfunction

  // Behavioural bank: 1-cycle read latency, byte-enabled writes.
  logic [31:0] sram [BS];
  initial begin
    for (int i = 0; i < BS; i++) sram[i] = pat(i);
    bank_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bank_req === 1'b1) begin
        if (bank_wen) bank_rdata = sram[bank_add];
        else for (int b = 0; b < 4; b++) if (bank_be[b]) sram[bank_add][8*b +: 8] = bank_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [BS];
  int          m_ptr;
  logic [NB-1:0] m_rv;
  int          m_idx;
  logic        m_rd;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check mid-cycle, then advance the model.
  task automatic step(output logic [NB-1:0] g, output logic [7:0] a);
    int win;
    int word;
    logic [NB-1:0] eg;
    @(negedge clk);
    g = gnt;
    a = bank_add;
    win = -1;
    for (int i = 0; i < NB; i++) begin
      int k;
      k = (m_ptr + i) % NB;
      if (win < 0 && req[k]) win = k;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    chk("gnt", gnt, eg);
    chk("bank_req", bank_req, (win >= 0));
    if (win >= 0) begin
      word = int'(add[win] >> 2) % BS;
      chk("bank_add", bank_add, word);
      chk("bank_wen", bank_wen, wen[win]);
      chk("bank_be", bank_be, be[win]);
      chk("bank_wdata", bank_wdata, data[win]);
    end
    chk("r_valid", r_valid, m_rv);
    if (m_rv != '0 && m_rd) chk("r_data", r_data[m_idx], m_rdata);
    m_rv = eg;
    if (win >= 0) begin
      m_idx = win;
      m_rd  = wen[win];
      if (wen[win]) m_rdata = ref_mem[word];
      else for (int b = 0; b < 4; b++) if (be[win][b]) ref_mem[word][8*b +: 8] = data[win][8*b +: 8];
      m_ptr = (win + 1) % NB;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    req = '1;
    wen = '1;
    while (init_done !== 1'b1 && n < BS + 8) begin
      @(negedge clk);
      chk("init_gnt", gnt, 0);
      chk("init_bank_wen", bank_wen, 0);
      n++;
      @(posedge clk);
      #1;
    end
    req = '0;
    chk("init_done", init_done, 1);
`ifdef TCDM_BANK_INIT_EN
    chk("init_len", n, BS);
    for (int i = 0; i < BS; i++) ref_mem[i] = 32'h0;
`endif
  endtask

  typedef struct {
    logic [NB-1:0] req;
    logic [31:0]   addr;
    logic [NB-1:0] exp_gnt;
    logic [7:0]    exp_add;
  } vec_t;

  vec_t tbl [14];
  logic [NB-1:0] g;
  logic [7:0]    a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0010, 32'h0000_0014, 4'b0010, 8'd5};
    tbl[1]  = '{4'b0010, 32'hFFFF_FC14, 4'b0010, 8'd5};
    tbl[2]  = '{4'b0011, 32'h0000_0020, 4'b0001, 8'd8};
    tbl[3]  = '{4'b1001, 32'h0000_0024, 4'b1000, 8'd9};
    tbl[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 8'd0};
    for (int i = 0; i < 8; i++) tbl[5+i] = '{4'b1111, 32'(4 * (20 + i)), 4'(1 << (i % 4)), 8'(20 + i)};
    tbl[13] = '{4'b0000, 32'h0000_0000, 4'b0000, 8'd0};

    for (int i = 0; i < BS; i++) ref_mem[i] = pat(i);
    m_ptr = 0; m_rv = '0; m_idx = 0; m_rd = 1'b0; m_rdata = '0;
    rst = 1'b1; req = '1; wen = '1; add = '0; be = '0; data = '0;

    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_bank_req", bank_req, 0);
`ifdef TCDM_BANK_INIT_EN
    chk("rst_init_done", init_done, 0);
`else
    chk("rst_init_done", init_done, 1);
`endif
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;
    wait_init();

`ifdef TCDM_BANK_INIT_EN
    req = 4'b0001; wen = '1; add[0] = 32'd400;
    step(g, a);
    req = '0;
    chk("init_word100", r_data[0], 32'h0);
`endif

    // Directed vectors from pointer 0.
    for (int v = 0; v < 14; v++) begin
      req = tbl[v].req;
      wen = '1;
      for (int j = 0; j < NB; j++) begin
        add[j] = tbl[v].addr; be[j] = 4'hF; data[j] = 32'h1111_0000 + 32'(v);
      end
      step(g, a);
      chk("tbl_gnt", g, tbl[v].exp_gnt);
      if (tbl[v].exp_gnt != '0) chk("tbl_add", a, tbl[v].exp_add);
    end

    // Write then read of word 7 with partial byte enables.
    req = 4'b0100; wen = 4'b1011; add[2] = 32'h1C; be[2] = 4'b0101; data[2] = 32'hDEAD_BEEF;
    step(g, a);
    req = 4'b0001; wen = '1; add[0] = 32'h1C;
    step(g, a);
    req = '0;
    chk("wr_rd_valid", r_valid, 4'b0001);
    chk("wr_rd_data", r_data[0], 32'h00AD_00EF);

    // Reset asserted the cycle after a grant.
    req = 4'b1111;
    step(g, a);
    chk("pre_rst_rvalid", r_valid, 4'b0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", r_valid, 0);
    chk("mid_rst_gnt", gnt, 0);
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;
    m_ptr = 0; m_rv = '0;
    wait_init();
    req = 4'b1111; wen = '1;
    step(g, a);
    chk("post_rst_ptr", g, 4'b0001);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom);
      wen = 4'($urandom);
      for (int j = 0; j < NB; j++) begin
        add[j] = $urandom;
        if ($urandom_range(0, 1) == 1) add[j][9:2] = 8'($urandom_range(0, 15));
        be[j] = 4'($urandom);
        data[j] = $urandom;
      end
      step(g, a);
    end
    req = '0;
    step(g, a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
